// File: rtl/chirp_cmd_pkg.sv
// Shared constants and state enums for the chirp command receiver.
package chirp_cmd_pkg;

    localparam logic [7:0] HDR_BYTE = 8'hA5;
    localparam logic [7:0] SF_MIN   = 8'd6;
    localparam logic [7:0] SF_MAX   = 8'd12;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        P_HDR,
        P_SF,
        P_BW,
        P_CHK
    } prs_state_t;

endpackage

// File: rtl/uart_rx_os16.sv
// 8N1 UART byte receiver, LSB first, with 16x oversampling.
//
// state    | meaning
// RX_IDLE  | line idle, watching for a low level on each tick
// RX_START | start bit seen, re-checked at oversample count 7
// RX_DATA  | sampling 8 data bits, one every 16 ticks
// RX_STOP  | sampling stop bit; after a framing error, waits for line high
module uart_rx_os16
    import chirp_cmd_pkg::*;
#(
    parameter int unsigned OVS_DIV          = 65,
    parameter int unsigned DIVIDER_BITWIDTH = 7
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic [7:0] o_byte_data,
    output logic       o_byte_valid,
    output logic       o_frame_err,
    output logic       o_tick
);

    logic [1:0]                  r_sync;
    logic [DIVIDER_BITWIDTH-1:0] r_div;
    rx_state_t                   r_state;
    logic [3:0]                  r_os_cnt;
    logic [2:0]                  r_bit_cnt;
    logic [7:0]                  r_shift;
    logic                        r_wait_high;
    logic                        r_byte_valid;
    logic                        r_frame_err;

    rx_state_t                   w_state_n;
    logic [3:0]                  w_os_cnt_n;
    logic [2:0]                  w_bit_cnt_n;
    logic [7:0]                  w_shift_n;
    logic                        w_wait_high_n;
    logic                        w_byte_valid_n;
    logic                        w_frame_err_n;
    logic                        w_rx;
    logic                        w_tick;

    assign w_rx   = r_sync[1];
    assign w_tick = (r_div == DIVIDER_BITWIDTH'(OVS_DIV - 1));

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_sync <= 2'b11;
        else       r_sync <= {r_sync[0], i_rx};
    end

    // Oversample divider: one tick per wrap of 0..OVS_DIV-1.
    always_ff @(posedge i_clk) begin
        if (i_rst)       r_div <= '0;
        else if (w_tick) r_div <= '0;
        else             r_div <= r_div + 1'b1;
    end

    // Byte FSM state and datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= RX_IDLE;
            r_os_cnt     <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_wait_high  <= 1'b0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_os_cnt     <= w_os_cnt_n;
            r_bit_cnt    <= w_bit_cnt_n;
            r_shift      <= w_shift_n;
            r_wait_high  <= w_wait_high_n;
            r_byte_valid <= w_byte_valid_n;
            r_frame_err  <= w_frame_err_n;
        end
    end

    // Byte FSM next-state and sampling decisions, evaluated only on ticks.
    always_comb begin
        w_state_n      = r_state;
        w_os_cnt_n     = r_os_cnt;
        w_bit_cnt_n    = r_bit_cnt;
        w_shift_n      = r_shift;
        w_wait_high_n  = r_wait_high;
        w_byte_valid_n = 1'b0;
        w_frame_err_n  = 1'b0;
        if (w_tick) begin
            case (r_state)
                RX_IDLE: begin
                    if (!w_rx) begin
                        w_state_n  = RX_START;
                        w_os_cnt_n = '0;
                    end
                end
                RX_START: begin
                    if (r_os_cnt == 4'd7) begin
                        if (!w_rx) begin
                            w_state_n   = RX_DATA;
                            w_os_cnt_n  = '0;
                            w_bit_cnt_n = '0;
                        end else begin
                            w_state_n = RX_IDLE;
                        end
                    end else begin
                        w_os_cnt_n = r_os_cnt + 4'd1;
                    end
                end
                RX_DATA: begin
                    if (r_os_cnt == 4'd15) begin
                        w_shift_n  = {w_rx, r_shift[7:1]};
                        w_os_cnt_n = '0;
                        if (r_bit_cnt == 3'd7) w_state_n = RX_STOP;
                        else                   w_bit_cnt_n = r_bit_cnt + 3'd1;
                    end else begin
                        w_os_cnt_n = r_os_cnt + 4'd1;
                    end
                end
                RX_STOP: begin
                    if (r_wait_high) begin
                        if (w_rx) begin
                            w_state_n     = RX_IDLE;
                            w_wait_high_n = 1'b0;
                        end
                    end else if (r_os_cnt == 4'd15) begin
                        if (w_rx) begin
                            w_byte_valid_n = 1'b1;
                            w_state_n      = RX_IDLE;
                        end else begin
                            w_frame_err_n = 1'b1;
                            w_wait_high_n = 1'b1;
                        end
                    end else begin
                        w_os_cnt_n = r_os_cnt + 4'd1;
                    end
                end
                default: w_state_n = RX_IDLE;
            endcase
        end
    end

    assign o_byte_data  = r_shift;
    assign o_byte_valid = r_byte_valid;
    assign o_frame_err  = r_frame_err;
    assign o_tick       = w_tick;

endmodule

// File: rtl/chirp_cmd_rx.sv
// Chirp configuration frame receiver: A5 | SF | BW | A5^SF^BW.
//
// state | meaning
// P_HDR | waiting for header byte 0xA5
// P_SF  | next byte is the spreading factor
// P_BW  | next byte is the bandwidth code
// P_CHK | next byte is the checksum; frame is validated and applied
module chirp_cmd_rx
    import chirp_cmd_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ      = 10_000_000,
    parameter int unsigned OVS_DIV          = 65,
    parameter int unsigned DIVIDER_BITWIDTH = 7,
    parameter int unsigned MAX_SF_WIDTH     = 8,
    parameter int unsigned BW_BITWIDTH      = 2,
    parameter int unsigned TIMEOUT_TICKS    = 640
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_rx,
    output logic [MAX_SF_WIDTH-1:0] o_sf,
    output logic [BW_BITWIDTH-1:0]  o_bw,
    output logic                    o_cfg_valid,
    output logic                    o_err
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_TICKS + 1);
    // Constant true whenever the clock is fast enough to oversample 16x;
    // otherwise the inactivity timer never advances.
    localparam logic CLK_OK = (CLK_FREQ_HZ >= 16 * OVS_DIV);

    logic [7:0]              w_byte;
    logic                    w_byte_valid;
    logic                    w_frame_err;
    logic                    w_tick;
    logic                    w_timeout;
    logic                    w_chk_ok;

    prs_state_t              r_pstate;
    logic [7:0]              r_sh_sf;
    logic [7:0]              r_sh_bw;
    logic [MAX_SF_WIDTH-1:0] r_sf;
    logic [BW_BITWIDTH-1:0]  r_bw;
    logic                    r_cfg_valid;
    logic                    r_err;
    logic [TO_W-1:0]         r_to_cnt;

    prs_state_t              w_pstate_n;
    logic [7:0]              w_sh_sf_n;
    logic [7:0]              w_sh_bw_n;
    logic [MAX_SF_WIDTH-1:0] w_sf_n;
    logic [BW_BITWIDTH-1:0]  w_bw_n;
    logic                    w_cfg_valid_n;
    logic                    w_err_n;

    uart_rx_os16 #(
        .OVS_DIV          (OVS_DIV),
        .DIVIDER_BITWIDTH (DIVIDER_BITWIDTH)
    ) u_uart (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_rx         (i_rx),
        .o_byte_data  (w_byte),
        .o_byte_valid (w_byte_valid),
        .o_frame_err  (w_frame_err),
        .o_tick       (w_tick)
    );

    assign w_timeout = (r_pstate != P_HDR) && (r_to_cnt == TO_W'(TIMEOUT_TICKS));

    assign w_chk_ok = (w_byte == (HDR_BYTE ^ r_sh_sf ^ r_sh_bw))
                   && (r_sh_sf >= SF_MIN) && (r_sh_sf <= SF_MAX)
                   && ((r_sh_bw >> BW_BITWIDTH) == 8'd0);

    // Inactivity timer: only runs mid-frame, cleared by every received byte.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_byte_valid || (r_pstate == P_HDR))
            r_to_cnt <= '0;
        else if (w_tick && CLK_OK && !w_timeout)
            r_to_cnt <= r_to_cnt + 1'b1;
    end

    // Parser state, shadow and applied configuration registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pstate    <= P_HDR;
            r_sh_sf     <= '0;
            r_sh_bw     <= '0;
            r_sf        <= MAX_SF_WIDTH'(7);
            r_bw        <= '0;
            r_cfg_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_pstate    <= w_pstate_n;
            r_sh_sf     <= w_sh_sf_n;
            r_sh_bw     <= w_sh_bw_n;
            r_sf        <= w_sf_n;
            r_bw        <= w_bw_n;
            r_cfg_valid <= w_cfg_valid_n;
            r_err       <= w_err_n;
        end
    end

    // Parser next-state; a received byte takes priority over a same-cycle timeout.
    always_comb begin
        w_pstate_n    = r_pstate;
        w_sh_sf_n     = r_sh_sf;
        w_sh_bw_n     = r_sh_bw;
        w_sf_n        = r_sf;
        w_bw_n        = r_bw;
        w_cfg_valid_n = 1'b0;
        w_err_n       = w_frame_err;
        if (w_byte_valid) begin
            case (r_pstate)
                P_HDR: if (w_byte == HDR_BYTE) w_pstate_n = P_SF;
                P_SF: begin
                    w_sh_sf_n  = w_byte;
                    w_pstate_n = P_BW;
                end
                P_BW: begin
                    w_sh_bw_n  = w_byte;
                    w_pstate_n = P_CHK;
                end
                P_CHK: begin
                    if (w_chk_ok) begin
                        w_sf_n        = MAX_SF_WIDTH'(r_sh_sf);
                        w_bw_n        = r_sh_bw[BW_BITWIDTH-1:0];
                        w_cfg_valid_n = 1'b1;
                    end else begin
                        w_err_n = 1'b1;
                    end
                    w_pstate_n = P_HDR;
                end
                default: w_pstate_n = P_HDR;
            endcase
        end else if (w_timeout) begin
            w_pstate_n = P_HDR;
            w_err_n    = 1'b1;
        end
    end

    assign o_sf        = r_sf;
    assign o_bw        = r_bw;
    assign o_cfg_valid = r_cfg_valid;
    assign o_err       = r_err;

endmodule

// File: tb/tb_chirp_cmd_rx.sv
// Scoreboard bench for chirp_cmd_rx, run with a fast oversample divider.
module tb_chirp_cmd_rx;

    localparam int OVS = 4;
    localparam int BIT = 16 * OVS;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] o_sf;
    logic [1:0] o_bw;
    logic       o_cfg_valid;
    logic       o_err;

    typedef struct {
        bit         is_cfg;
        logic [7:0] sf;
        logic [1:0] bw;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] m_frame[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    chirp_cmd_rx #(
        .CLK_FREQ_HZ      (10_000_000),
        .OVS_DIV          (OVS),
        .DIVIDER_BITWIDTH (7),
        .MAX_SF_WIDTH     (8),
        .BW_BITWIDTH      (2),
        .TIMEOUT_TICKS    (640)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rx        (rx),
        .o_sf        (o_sf),
        .o_bw        (o_bw),
        .o_cfg_valid (o_cfg_valid),
        .o_err       (o_err)
    );

    // Reference model: collect bytes from a 0xA5 header, judge complete frames.
    task automatic model_byte(input logic [7:0] b);
        logic [7:0] sf, bw, ck;
        ev_t e;
        if (m_frame.size() == 0) begin
            if (b == 8'hA5) m_frame.push_back(b);
        end else begin
            m_frame.push_back(b);
            if (m_frame.size() == 4) begin
                sf = m_frame[1]; bw = m_frame[2]; ck = m_frame[3];
                e.sf = sf; e.bw = bw[1:0];
                e.is_cfg = (ck == (8'hA5 ^ sf ^ bw)) && (sf >= 6) && (sf <= 12) && (bw < 4);
                exp_q.push_back(e);
                m_frame.delete();
            end
        end
    endtask

    task automatic push_err();
        ev_t e;
        e.is_cfg = 1'b0; e.sf = '0; e.bw = '0;
        exp_q.push_back(e);
    endtask

    task automatic model_timeout();
        if (m_frame.size() != 0) begin
            push_err();
            m_frame.delete();
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        if (stop_ok) model_byte(b);
        else         push_err();
        rx = 1'b0;
        repeat (BIT) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(posedge clk);
        end
        rx = stop_ok;
        repeat (BIT) @(posedge clk);
        if (!stop_ok) idle(BIT);
        rx = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] sf, input logic [7:0] bw, input logic [7:0] ck);
        send_byte(8'hA5, 1'b1);
        send_byte(sf, 1'b1);
        send_byte(bw, 1'b1);
        send_byte(ck, 1'b1);
        idle(2 * BIT);
    endtask

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: every strobe is matched against the next expected event.
    always @(negedge clk) begin
        ev_t e;
        if (!rst && (o_cfg_valid || o_err)) begin
            n_cmp++;
            if (o_cfg_valid && o_err) begin
                n_bad++;
                $display("FAIL strobe_excl: cfg_valid and err both high at %0t", $time);
            end else if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_strobe: cfg=%0b err=%0b sf=%0d bw=%0d at %0t",
                         o_cfg_valid, o_err, o_sf, o_bw, $time);
            end else begin
                e = exp_q.pop_front();
                if (e.is_cfg != o_cfg_valid ||
                    (e.is_cfg && (o_sf != e.sf || o_bw != e.bw))) begin
                    n_bad++;
                    $display("FAIL event: got cfg=%0b sf=%0d bw=%0d, expected cfg=%0b sf=%0d bw=%0d at %0t",
                             o_cfg_valid, o_sf, o_bw, e.is_cfg, e.sf, e.bw, $time);
                end
            end
        end
    end

    initial begin
        logic [7:0] sf, bw, ck, junk;
        int         budget;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk); #2;
        check("reset_sf", o_sf, 7);
        check("reset_bw", o_bw, 0);
        check("reset_cfg_valid", o_cfg_valid, 0);
        check("reset_err", o_err, 0);
        rst = 1'b0;
        idle(2 * BIT);

        // Basic, bad checksum, then corrected frame.
        send_frame(8'h07, 8'h01, 8'hA3);
        send_frame(8'h0C, 8'h02, 8'h00);
        send_frame(8'h0C, 8'h02, 8'hAB);
        check("after_good_sf", o_sf, 12);
        check("after_good_bw", o_bw, 2);

        // Range checks with valid checksums.
        send_frame(8'h0D, 8'h00, 8'hA8);
        send_frame(8'h07, 8'h04, 8'hA6);
        check("range_hold_sf", o_sf, 12);
        check("range_hold_bw", o_bw, 2);

        // Framing error on the header, trailing bytes ignored.
        send_byte(8'hA5, 1'b0);
        send_byte(8'h07, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'hA3, 1'b1);
        idle(2 * BIT);

        // Short glitch on an idle line.
        rx = 1'b0;
        repeat (18) @(posedge clk);
        idle(3 * BIT);

        // Timeout after a partial frame, then a full frame.
        send_byte(8'hA5, 1'b1);
        send_byte(8'h07, 1'b1);
        model_timeout();
        idle(700 * OVS);
        send_frame(8'h08, 8'h03, 8'hA5 ^ 8'h08 ^ 8'h03);
        check("post_timeout_sf", o_sf, 8);

        // Reset in the middle of the BW byte.
        send_byte(8'hA5, 1'b1);
        send_byte(8'h09, 1'b1);
        rx = 1'b0;
        repeat (BIT) @(posedge clk);
        rx = 1'b1;
        repeat (3 * BIT) @(posedge clk);
        rst = 1'b1;
        m_frame.delete();
        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        check("midrst_sf", o_sf, 7);
        check("midrst_bw", o_bw, 0);
        rst = 1'b0;
        idle(12 * BIT);
        send_frame(8'h0B, 8'h01, 8'hA5 ^ 8'h0B ^ 8'h01);
        check("post_rst_sf", o_sf, 11);
        check("post_rst_bw", o_bw, 1);

        // Randomized frames, some with junk before the header or bad checksum.
        for (int n = 0; n < 10; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                junk = 8'($urandom_range(0, 255));
                if (junk == 8'hA5) junk = 8'h5A;
                send_byte(junk, 1'b1);
            end
            sf = 8'($urandom_range(4, 14));
            bw = 8'($urandom_range(0, 5));
            ck = 8'hA5 ^ sf ^ bw;
            if ($urandom_range(0, 3) == 0) ck = ck ^ 8'($urandom_range(1, 255));
            send_frame(sf, bw, ck);
            idle($urandom_range(0, 2 * BIT));
        end

        budget = 40 * BIT;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        idle(4 * BIT);
        check("pending_events", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
